inertial_gate_array: RTL and testbench
======================================

Name: inertial_gate_array

Overview:
- NCH independent two-input gate channels. Each channel's gate output passes through a clocked inertial-delay filter with separate, run-time-programmable rise and fall delays, counted in clock cycles.
- Pulses shorter than the applicable delay are swallowed.
- Synthesizable, parametrised successor to the team's gate-primitive delay modelling blocks. Used as the glitch-filtering front end for asynchronous control lines.

Parameters:
NCH, 4, number of channels (>=1)
DW, 4, width of delay counters and config values
MODE, 1, gate function for all channels: 0=AND, 1=OR, 2=XOR, 3=BUF (a only)
RISE_DLY, 2, reset value of every channel's rise delay (1..2^DW-1)
FALL_DLY, 1, reset value of every channel's fall delay (1..2^DW-1)
GW, 8, glitch counter width (used only with the optional feature)

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  reset; synchronous, active-low
a_i  in  NCH  gate input a, one bit per channel
b_i  in  NCH  gate input b, one bit per channel (ignored when MODE=3)
cfg_we  in  1  write strobe for the delay registers
cfg_ch  in  max(1,$clog2(NCH))  channel index for the write
cfg_rise  in  DW  new rise delay
cfg_fall  in  DW  new fall delay
y_o  out  NCH  filtered gate output
busy_o  out  NCH  channel has a pending transition (cnt != 0)
glitch_cnt_o  out  NCH*GW  swallowed-pulse counts; present only with GLITCH_CNT_EN

Behaviour:
- Reset: one clock, one reset. The reset is synchronous and active-low. When rst_n=0 at a clk edge:
  - y_o=0 and busy_o=0 for all channels.
  - Every cnt=0.
  - Every delay register is set to RISE_DLY/FALL_DLY.
  - Every glitch counter is set to 0.
- Reset wins over every other event, including one mid-pending.
- Gate value per channel: g = MODE(a_i[n], b_i[n]), combinational, sampled at each edge.
- Target delay: D = rise_reg when g=1, D = fall_reg when g=0.
- Per-channel two-state FSM: STABLE (cnt=0) and PEND (cnt!=0). Per edge, first matching rule applies:
  - g==y: cnt<=0. If the FSM was in PEND, this counts as a swallowed pulse.
  - g!=y and cnt>=D-1: y<=g, cnt<=0 (commit).
  - g!=y otherwise: cnt<=cnt+1.
- Latency:
  - A change sampled first at edge k appears on y_o after edge k+D-1.
  - D=1 gives a one-register delay.
  - An input pulse of W consecutive sampled cycles propagates iff W>=D_rise. The output-high width is then W - D_rise + D_fall.
- busy_o[n] = (cnt[n] != 0), registered.
- Config write, on an edge with cfg_we=1:
  - rise_reg[cfg_ch] <= cfg_rise and fall_reg[cfg_ch] <= cfg_fall.
  - A written value of 0 is stored as 1.
  - cfg_ch >= NCH: write ignored.
  - The new value is used from the next edge. If a channel in PEND already has cnt >= newD-1, it commits at that next edge.
  - A write and an input change on the same edge: the counter uses the old delay on that edge.
- Counter never exceeds 2^DW-2, so it cannot wrap.

Optional Feature:
- Macro: INERTIAL_GATE_GLITCH_CNT_EN.
- Defined:
  - Each channel has a GW-bit counter that increments on every swallowed pulse (PEND to STABLE without commit).
  - The counter saturates at 2^GW-1.
  - It is cleared by reset and by a cfg_we write to that channel.
  - glitch_cnt_o[n*GW +: GW] carries channel n's count.
- Undefined: the glitch_cnt_o port and all counter logic are absent. Filter behaviour is identical in both builds.

Decomposition:
- Package inertial_gate_pkg holds:
  - gate_mode_e enum (AND/OR/XOR/BUF).
  - Function gate_eval(mode, a, b).
  - Constant for the minimum legal delay (1).
- Sub-module inertial_gate_ch holds one channel: FSM, cnt, delay registers, optional glitch counter. The top module generates NCH instances and decodes cfg_ch.

Test Plan:
- Reset and delay latency: MODE=1, defaults 2/1. Assert rst_n=0 with a_i=1, b_i=0 → y_o=0 and busy_o=0. Release reset → y_o[0] rises 2 edges after the first sample of a_i[0]=1. Drop a_i[0] → y_o[0] falls 1 edge later.
- Pulse swallowed: MODE=0, rise delay 3. Drive a=b=1 for 2 cycles → y_o stays 0. busy_o is 1 for 2 cycles. Glitch count reads 1 (with macro).
- Pulse passes: MODE=0, rise 3, fall 2. Drive a 5-cycle high pulse → y_o high for exactly 4 cycles (5-3+2).
- Runtime reconfig: channel 2 in PEND with cnt=3 under rise 6. Write rise=2 → commit on the next edge. Write to cfg_ch=NCH → no register changes.
- Zero-delay write: write cfg_rise=0 → channel behaves as D=1 (one-edge latency).
- Reset mid-pending plus saturation: assert rst_n=0 while cnt=2 → y_o=0, cnt=0, delays restored to defaults. With GW=2, swallow 5 pulses → counter reads 3.

Source files
------------

// File: rtl/inertial_gate_pkg.sv
// Shared types and helpers for the inertial-delay gate array.
package inertial_gate_pkg;

    typedef enum logic [1:0] {
        GATE_AND = 2'd0,
        GATE_OR  = 2'd1,
        GATE_XOR = 2'd2,
        GATE_BUF = 2'd3
    } gate_mode_e;

    // Smallest delay a channel can hold; a written 0 is promoted to this.
    localparam int MIN_DLY = 1;

    function automatic logic gate_eval(input gate_mode_e mode, input logic a, input logic b);
        case (mode)
            GATE_AND: gate_eval = a & b;
            GATE_OR:  gate_eval = a | b;
            GATE_XOR: gate_eval = a ^ b;
            default:  gate_eval = a;
        endcase
    endfunction

endpackage

// File: rtl/inertial_gate_ch.sv
// One gate channel with a clocked inertial-delay filter and programmable rise/fall delays.
// INERTIAL_GATE_GLITCH_CNT_EN adds a saturating swallowed-pulse counter.
module inertial_gate_ch
    import inertial_gate_pkg::*;
#(
    parameter int DW       = 4,
    parameter int MODE     = 1,
    parameter int RISE_DLY = 2,
    parameter int FALL_DLY = 1,
    parameter int GW       = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          a,
    input  logic          b,
    input  logic          we,
    input  logic [DW-1:0] rise_wr,
    input  logic [DW-1:0] fall_wr,
`ifdef INERTIAL_GATE_GLITCH_CNT_EN
    output logic [GW-1:0] glitch_cnt,
`endif
    output logic          y,
    output logic          busy
);

    typedef enum logic {STABLE, PEND} st_e;

    localparam gate_mode_e      GMODE    = gate_mode_e'(MODE[1:0]);
    localparam logic [DW-1:0]   RISE_RST = DW'(RISE_DLY);
    localparam logic [DW-1:0]   FALL_RST = DW'(FALL_DLY);
    localparam logic [DW-1:0]   DLY_MIN  = DW'(MIN_DLY);

    st_e           st_q, st_d;
    logic [DW-1:0] cnt_q, cnt_d;
    logic [DW-1:0] rise_q, fall_q;
    logic [DW-1:0] dly, dly_m1;
    logic [DW-1:0] rise_new, fall_new;
    logic          y_q, y_d, g, swallow, busy_q;

    always_comb begin
        st_d    = STABLE;
        cnt_d   = '0;
        y_d     = y_q;
        swallow = 1'b0;
        g       = gate_eval(GMODE, a, b);
        dly     = g ? rise_q : fall_q;
        dly_m1  = dly - DLY_MIN;
        if (g == y_q) begin
            swallow = (st_q == PEND);
        end else if (cnt_q >= dly_m1) begin
            y_d = g;
        end else begin
            cnt_d = cnt_q + 1'b1;
            st_d  = PEND;
        end
    end

    assign rise_new = (rise_wr == '0) ? DLY_MIN : rise_wr;
    assign fall_new = (fall_wr == '0) ? DLY_MIN : fall_wr;

    // Delay registers change after this edge, so the filter above always sees the old values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            st_q   <= STABLE;
            cnt_q  <= '0;
            y_q    <= 1'b0;
            busy_q <= 1'b0;
            rise_q <= RISE_RST;
            fall_q <= FALL_RST;
        end else begin
            st_q   <= st_d;
            cnt_q  <= cnt_d;
            y_q    <= y_d;
            busy_q <= (cnt_d != '0);
            if (we) begin
                rise_q <= rise_new;
                fall_q <= fall_new;
            end
        end
    end

`ifdef INERTIAL_GATE_GLITCH_CNT_EN
    logic [GW-1:0] gl_q;

    // A config write clears the count even if a pulse is swallowed on the same edge.
    always_ff @(posedge clk) begin
        if (!rst_n)                      gl_q <= '0;
        else if (we)                     gl_q <= '0;
        else if (swallow && gl_q != '1)  gl_q <= gl_q + 1'b1;
    end

    assign glitch_cnt = gl_q;
`else
    logic unused_swallow;
    assign unused_swallow = swallow;
`endif

    assign y    = y_q;
    assign busy = busy_q;

endmodule

// File: rtl/inertial_gate_array.sv
// NCH independent gate channels, each behind an inertial-delay glitch filter.
// INERTIAL_GATE_GLITCH_CNT_EN exposes per-channel swallowed-pulse counts on glitch_cnt_o.
module inertial_gate_array
    import inertial_gate_pkg::*;
#(
    parameter int NCH      = 4,
    parameter int DW       = 4,
    parameter int MODE     = 1,
    parameter int RISE_DLY = 2,
    parameter int FALL_DLY = 1,
    parameter int GW       = 8,
    localparam int CHW     = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NCH-1:0]     a_i,
    input  logic [NCH-1:0]     b_i,
    input  logic               cfg_we,
    input  logic [CHW-1:0]     cfg_ch,
    input  logic [DW-1:0]      cfg_rise,
    input  logic [DW-1:0]      cfg_fall,
`ifdef INERTIAL_GATE_GLITCH_CNT_EN
    output logic [NCH*GW-1:0]  glitch_cnt_o,
`endif
    output logic [NCH-1:0]     y_o,
    output logic [NCH-1:0]     busy_o
);

    logic [NCH-1:0] ch_we;

    for (genvar n = 0; n < NCH; n++) begin : g_ch
        // Out-of-range cfg_ch never matches, so such writes are dropped.
        assign ch_we[n] = cfg_we && (cfg_ch == CHW'(n));

        inertial_gate_ch #(
            .DW       (DW),
            .MODE     (MODE),
            .RISE_DLY (RISE_DLY),
            .FALL_DLY (FALL_DLY),
            .GW       (GW)
        ) u_ch (
            .clk        (clk),
            .rst_n      (rst_n),
            .a          (a_i[n]),
            .b          (b_i[n]),
            .we         (ch_we[n]),
            .rise_wr    (cfg_rise),
            .fall_wr    (cfg_fall),
`ifdef INERTIAL_GATE_GLITCH_CNT_EN
            .glitch_cnt (glitch_cnt_o[n*GW +: GW]),
`endif
            .y          (y_o[n]),
            .busy       (busy_o[n])
        );
    end

endmodule

// File: tb/tb_inertial_gate_array.sv
// Scoreboard bench for inertial_gate_array: directed test-plan phases followed by random traffic.
module tb_inertial_gate_array;

    localparam int NCH  = 3;
    localparam int DW   = 4;
    localparam int MODE = 0;
    localparam int RDLY = 2;
    localparam int FDLY = 1;
    localparam int GW   = 2;
    localparam int CHW  = (NCH > 1) ? $clog2(NCH) : 1;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic [NCH-1:0]     a_i = '0, b_i = '0;
    logic               cfg_we = 1'b0;
    logic [CHW-1:0]     cfg_ch = '0;
    logic [DW-1:0]      cfg_rise = '0, cfg_fall = '0;
    logic [NCH-1:0]     y_o, busy_o;
    logic [NCH*GW-1:0]  gl_act;

`ifdef INERTIAL_GATE_GLITCH_CNT_EN
    logic [NCH*GW-1:0]  glitch_cnt_o;
    assign gl_act = glitch_cnt_o;
`else
    assign gl_act = '0;
`endif

    inertial_gate_array #(
        .NCH(NCH), .DW(DW), .MODE(MODE), .RISE_DLY(RDLY), .FALL_DLY(FDLY), .GW(GW)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .a_i          (a_i),
        .b_i          (b_i),
        .cfg_we       (cfg_we),
        .cfg_ch       (cfg_ch),
        .cfg_rise     (cfg_rise),
        .cfg_fall     (cfg_fall),
`ifdef INERTIAL_GATE_GLITCH_CNT_EN
        .glitch_cnt_o (glitch_cnt_o),
`endif
        .y_o          (y_o),
        .busy_o       (busy_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [NCH-1:0]    y;
        logic [NCH-1:0]    busy;
        logic [NCH*GW-1:0] gl;
    } exp_t;

    exp_t sb[$];
    int   tests = 0, fails = 0, cyc = 0;
    bit   count_hi = 0;
    int   hi_cycles = 0;

    // Reference state: output level, cycles the disagreeing level has persisted, delays, glitches.
    int m_y[NCH], m_cnt[NCH], m_r[NCH], m_f[NCH], m_gl[NCH];

    function automatic int gate(input int a, input int b);
        case (MODE)
            0: return a & b;
            1: return a | b;
            2: return a ^ b;
            default: return a;
        endcase
    endfunction

    task automatic step(input bit rst, input logic [NCH-1:0] a, input logic [NCH-1:0] b,
                        input bit we = 0, input int ch = 0, input int r = 0, input int f = 0);
        exp_t e;
        @(negedge clk);
        rst_n = rst; a_i = a; b_i = b; cfg_we = we;
        cfg_ch = CHW'(ch); cfg_rise = DW'(r); cfg_fall = DW'(f);
        for (int n = 0; n < NCH; n++) begin
            if (!rst) begin
                m_y[n] = 0; m_cnt[n] = 0; m_r[n] = RDLY; m_f[n] = FDLY; m_gl[n] = 0;
            end else begin
                int g, d;
                g = gate(int'(a[n]), int'(b[n]));
                d = (g == 1) ? m_r[n] : m_f[n];
                if (g == m_y[n]) begin
                    if (m_cnt[n] > 0 && m_gl[n] < (1 << GW) - 1) m_gl[n]++;
                    m_cnt[n] = 0;
                end else if (m_cnt[n] + 1 >= d) begin
                    m_y[n] = g; m_cnt[n] = 0;
                end else begin
                    m_cnt[n]++;
                end
                if (we && ch == n) begin
                    m_r[n] = (r == 0) ? 1 : r;
                    m_f[n] = (f == 0) ? 1 : f;
                    m_gl[n] = 0;
                end
            end
            e.y[n] = (m_y[n] != 0);
            e.busy[n] = (m_cnt[n] != 0);
`ifdef INERTIAL_GATE_GLITCH_CNT_EN
            e.gl[n*GW +: GW] = GW'(m_gl[n]);
`else
            e.gl[n*GW +: GW] = '0;
`endif
        end
        sb.push_back(e);
    endtask

    // Monitor: outputs are presented every cycle, checked just after the edge.
    initial forever begin
        exp_t e;
        @(posedge clk);
        #1;
        cyc++;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            tests++;
            if (y_o !== e.y || busy_o !== e.busy || gl_act !== e.gl) begin
                fails++;
                $display("FAIL out cyc=%0d y=%b exp=%b busy=%b exp=%b gl=%h exp=%h",
                         cyc, y_o, e.y, busy_o, e.busy, gl_act, e.gl);
            end
        end
        if (count_hi && y_o[0]) hi_cycles++;
    end

    initial begin
        // Reset with inputs driven high, then default 2/1 latency on channel 0.
        step(0, 3'b111, 3'b111);
        step(0, 3'b111, 3'b111);
        repeat (4) step(1, 3'b001, 3'b001);
        repeat (3) step(1, 3'b000, 3'b001);

        // Swallowed pulse under rise delay 3.
        step(1, 3'b000, 3'b000, 1, 0, 3, 2);
        repeat (2) step(1, 3'b001, 3'b001);
        repeat (3) step(1, 3'b000, 3'b000);

        // A 5-cycle pulse through rise 3 / fall 2 must be high for 4 cycles.
        count_hi = 1;
        repeat (5) step(1, 3'b001, 3'b001);
        repeat (6) step(1, 3'b000, 3'b000);
        count_hi = 0;

        // Shorten channel 2's rise delay while it is pending.
        step(1, 3'b000, 3'b000, 1, 2, 6, 1);
        repeat (3) step(1, 3'b100, 3'b100);
        step(1, 3'b100, 3'b100, 1, 2, 2, 1);
        repeat (2) step(1, 3'b100, 3'b100);
        step(1, 3'b100, 3'b100, 1, NCH, 0, 0);
        repeat (3) step(1, 3'b000, 3'b000);

        // Zero-valued write behaves as delay 1.
        step(1, 3'b000, 3'b000, 1, 1, 0, 0);
        repeat (2) step(1, 3'b010, 3'b010);
        repeat (2) step(1, 3'b000, 3'b000);

        // Reset while channel 0 is pending, then defaults and glitch saturation.
        repeat (2) step(1, 3'b001, 3'b001);
        step(0, 3'b001, 3'b001);
        repeat (3) step(1, 3'b001, 3'b001);
        repeat (2) step(1, 3'b000, 3'b000);
        for (int i = 0; i < 5; i++) begin
            step(1, 3'b001, 3'b001);
            step(1, 3'b000, 3'b000);
        end

        for (int i = 0; i < 400; i++) begin
            bit rst, we;
            rst = ($urandom_range(63) != 0);
            we  = ($urandom_range(7) == 0);
            step(rst, NCH'($urandom), NCH'($urandom), we,
                 int'($urandom_range(NCH)), int'($urandom_range(15)), int'($urandom_range(15)));
        end

        repeat (3) @(negedge clk);
        tests++;
        if (hi_cycles != 4) begin
            fails++;
            $display("FAIL pulse_width high=%0d exp=4", hi_cycles);
        end
        tests++;
        if (sb.size() != 0) begin
            fails++;
            $display("FAIL drain left=%0d exp=0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
